// File: rtl/led_btn_mmio_if.sv
// led_btn_mmio_if -- load/store bus between a core and the LED/button block.
//   addr   : byte address from the core
//   wdata  : store data
//   wr_en  : one-cycle store request
//   rd_en  : one-cycle load request
//   rdata  : load data, nonzero only alongside ready
//   ready  : one-cycle completion pulse
interface led_btn_mmio_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output addr, wdata, wr_en, rd_en,
        input  rdata, ready
    );

    modport slave (
        input  addr, wdata, wr_en, rd_en,
        output rdata, ready
    );
endinterface

// File: rtl/led_btn_mmio.sv
// led_btn_mmio -- memory-mapped LED register plus debounced push buttons with
// sticky rising-edge flags and a level interrupt.
//   clk   : sole clock, rising edge
//   rst   : synchronous, active-high reset
//   bus   : load/store slave port (addr, wdata, wr_en, rd_en, rdata, ready)
//   btn   : raw asynchronous button levels
//   leds  : LED register contents
//   irq   : |(EDGE & IRQ_EN)
// Register window (addr[3:2]): 0 LED, 1 BTN (RO), 2 EDGE (W1C), 3 IRQ_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for an in-range request
// ST_RESP | ready high for one cycle, rdata holds the sampled load data
module led_btn_mmio #(
    parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    led_btn_mmio_if.slave        bus,
    input  logic [3:0]           btn,
    output logic [7:0]           leds,
    output logic                 irq
);

    typedef enum logic {ST_IDLE, ST_RESP} state_t;

    localparam logic [7:0] DB_TC = 8'(DEBOUNCE_CYCLES);

    state_t          state_q, state_d;
    logic [7:0]      led_q, led_d;
    logic [3:0]      irq_en_q, irq_en_d;
    logic [3:0]      edge_q, edge_d;
    logic [3:0]      stable_q, stable_d;
    logic [3:0]      sync1_q, sync1_d;
    logic [3:0]      sync2_q, sync2_d;
    logic [3:0][7:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            in_range;
    logic            accept;
    logic [3:0]      rise;
    logic [3:0]      w1c;
    logic            unused_ok;

    assign unused_ok = ^{bus.addr[1:0], bus.wdata[31:8]};

    always_comb begin
        state_d  = state_q;
        led_d    = led_q;
        irq_en_d = irq_en_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rdata_d  = '0;
        w1c      = '0;
        sync1_d  = btn;
        sync2_d  = sync1_q;

        in_range = (bus.addr[31:4] == BASE_ADDR[31:4]);
        accept   = (state_q == ST_IDLE) && (bus.wr_en || bus.rd_en) && in_range;

        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] + 8'd1 == DB_TC) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
        rise = stable_d & ~stable_q;

        // A simultaneous write and read is a write; rdata stays 0 for it.
        if (accept && bus.wr_en) begin
            case (bus.addr[3:2])
                2'd0:    led_d    = bus.wdata[7:0];
                2'd2:    w1c      = bus.wdata[3:0];
                2'd3:    irq_en_d = bus.wdata[3:0];
                default: ;
            endcase
        end else if (accept) begin
            case (bus.addr[3:2])
                2'd0:    rdata_d = {24'd0, led_q};
                2'd1:    rdata_d = {28'd0, stable_q};
                2'd2:    rdata_d = {28'd0, edge_q};
                default: rdata_d = {28'd0, irq_en_q};
            endcase
        end

        // A new rising edge beats a clear of the same bit.
        edge_d = (edge_q & ~w1c) | rise;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            led_q    <= '0;
            irq_en_q <= '0;
            edge_q   <= '0;
            stable_q <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            led_q    <= led_d;
            irq_en_q <= irq_en_d;
            edge_q   <= edge_d;
            stable_q <= stable_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.ready = (state_q == ST_RESP);
    assign bus.rdata = rdata_q;
    assign leds      = led_q;
    assign irq       = |(edge_q & irq_en_q);

endmodule

// File: tb/tb_led_btn_mmio.sv
module tb_led_btn_mmio;

    logic       clk;
    logic       rst;
    logic [3:0] btn;
    logic [7:0] leds;
    logic       irq;

    int checks = 0;
    int errors = 0;

    led_btn_mmio_if bus_if ();

    led_btn_mmio #(
        .BASE_ADDR       (32'h0000_1000),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus_if),
        .btn  (btn),
        .leds (leds),
        .irq  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_ready;
        logic [31:0] exp_rdata;
        logic [7:0]  exp_leds;
        bit          exp_irq;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Present a request for one cycle; return at the negedge inside the
    // response cycle with the request removed.
    task automatic do_req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.wr_en = wr;
        bus_if.rd_en = rd;
        bus_if.addr  = a;
        bus_if.wdata = d;
        @(negedge clk);
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        do_req(1'b0, 1'b1, a, 32'd0);
        chk({name, "_ready"}, {31'd0, bus_if.ready}, 32'd1);
        chk(name, bus_if.rdata, exp);
    endtask

    initial begin
        //            wr  rd  addr           wdata          rdy rdata          leds   irq
        vecs[0]  = '{1, 0, 32'h0000_1000, 32'h0000_00A5, 1, 32'h0,         8'hA5, 0};
        vecs[1]  = '{0, 1, 32'h0000_1000, 32'h0,         1, 32'h0000_00A5, 8'hA5, 0};
        vecs[2]  = '{0, 1, 32'h0000_1004, 32'h0,         1, 32'h0,         8'hA5, 0};
        vecs[3]  = '{1, 0, 32'h0000_2000, 32'h0000_0077, 0, 32'h0,         8'hA5, 0};
        vecs[4]  = '{1, 1, 32'h0000_1000, 32'h0000_003C, 1, 32'h0,         8'h3C, 0};
        vecs[5]  = '{1, 0, 32'h0000_100C, 32'hFFFF_FFF5, 1, 32'h0,         8'h3C, 0};
        vecs[6]  = '{0, 1, 32'h0000_100C, 32'h0,         1, 32'h0000_0005, 8'h3C, 0};
        vecs[7]  = '{0, 1, 32'h0000_100F, 32'h0,         1, 32'h0000_0005, 8'h3C, 0};
        vecs[8]  = '{1, 0, 32'h0000_1004, 32'h0000_000F, 1, 32'h0,         8'h3C, 0};
        vecs[9]  = '{0, 1, 32'h0000_1004, 32'h0,         1, 32'h0,         8'h3C, 0};
        vecs[10] = '{0, 1, 32'h0000_0000, 32'h0,         0, 32'h0,         8'h3C, 0};
        vecs[11] = '{1, 0, 32'h0000_1002, 32'hFFFF_FF11, 1, 32'h0,         8'h11, 0};
        vecs[12] = '{0, 1, 32'h0000_1008, 32'h0,         1, 32'h0,         8'h11, 0};
        vecs[13] = '{1, 0, 32'h0000_100C, 32'h0,         1, 32'h0,         8'h11, 0};

        rst          = 1'b1;
        btn          = 4'd0;
        bus_if.addr  = 32'd0;
        bus_if.wdata = 32'd0;
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, bus_if.ready}, 32'd0);
        chk("rst_rdata", bus_if.rdata, 32'd0);
        chk("rst_leds", {24'd0, leds}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            do_req(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_ready", i), {31'd0, bus_if.ready}, {31'd0, vecs[i].exp_ready});
            chk($sformatf("vec%0d_rdata", i), bus_if.rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_leds", i), {24'd0, leds}, {24'd0, vecs[i].exp_leds});
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
            @(negedge clk);
            chk($sformatf("vec%0d_ready_low", i), {31'd0, bus_if.ready}, 32'd0);
        end

        // Glitch of two cycles must be filtered out.
        @(negedge clk);
        btn = 4'b0100;
        repeat (2) @(negedge clk);
        btn = 4'b0000;
        repeat (10) @(negedge clk);
        rd_chk("short_btn", 32'h0000_1004, 32'h0);
        rd_chk("short_edge", 32'h0000_1008, 32'h0);

        // Held press debounces, sets EDGE, drives irq once enabled.
        @(negedge clk);
        btn = 4'b0100;
        repeat (10) @(negedge clk);
        chk("held_irq_masked", {31'd0, irq}, 32'd0);
        rd_chk("held_btn", 32'h0000_1004, 32'h4);
        rd_chk("held_edge", 32'h0000_1008, 32'h4);
        do_req(1'b1, 1'b0, 32'h0000_1008, 32'h0000_000B);
        chk("w1c_other_ready", {31'd0, bus_if.ready}, 32'd1);
        rd_chk("w1c_other_edge", 32'h0000_1008, 32'h4);
        do_req(1'b1, 1'b0, 32'h0000_100C, 32'h0000_0004);
        chk("irq_en_irq", {31'd0, irq}, 32'd1);
        do_req(1'b1, 1'b0, 32'h0000_1008, 32'h0000_0004);
        chk("w1c_ready", {31'd0, bus_if.ready}, 32'd1);
        chk("w1c_irq", {31'd0, irq}, 32'd0);
        rd_chk("w1c_edge", 32'h0000_1008, 32'h0);

        // Release: BTN falls, no edge recorded.
        btn = 4'b0000;
        repeat (10) @(negedge clk);
        rd_chk("release_btn", 32'h0000_1004, 32'h0);
        rd_chk("release_edge", 32'h0000_1008, 32'h0);

        // btn[1] stable value flips on the 6th rising edge after it is driven;
        // the W1C of bit 1 is timed onto that same edge and must lose.
        @(negedge clk);
        btn = 4'b0010;
        repeat (4) @(negedge clk);
        do_req(1'b1, 1'b0, 32'h0000_1008, 32'h0000_0002);
        rd_chk("setwins_edge", 32'h0000_1008, 32'h2);
        rd_chk("setwins_btn", 32'h0000_1004, 32'h2);

        // Second write during RESP is dropped.
        @(negedge clk);
        bus_if.wr_en = 1'b1;
        bus_if.addr  = 32'h0000_1000;
        bus_if.wdata = 32'h0000_0022;
        @(negedge clk);
        chk("drop_first_ready", {31'd0, bus_if.ready}, 32'd1);
        chk("drop_first_leds", {24'd0, leds}, 32'h22);
        bus_if.wdata = 32'h0000_00FF;
        @(negedge clk);
        bus_if.wr_en = 1'b0;
        chk("drop_second_ready", {31'd0, bus_if.ready}, 32'd0);
        chk("drop_second_leds", {24'd0, leds}, 32'h22);

        // Reset during the response of a read.
        do_req(1'b0, 1'b1, 32'h0000_1000, 32'd0);
        chk("rstresp_ready", {31'd0, bus_if.ready}, 32'd1);
        chk("rstresp_rdata", bus_if.rdata, 32'h22);
        rst = 1'b1;
        @(negedge clk);
        chk("rstresp_ready_low", {31'd0, bus_if.ready}, 32'd0);
        chk("rstresp_rdata_low", bus_if.rdata, 32'd0);
        chk("rstresp_leds", {24'd0, leds}, 32'd0);
        chk("rstresp_irq", {31'd0, irq}, 32'd0);
        bus_if.wr_en = 1'b1;
        bus_if.addr  = 32'h0000_1000;
        bus_if.wdata = 32'h0000_0055;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, bus_if.ready}, 32'd0);
        bus_if.wr_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready2", {31'd0, bus_if.ready}, 32'd0);
        chk("rst_req_leds", {24'd0, leds}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
